// File: rtl/pc_branch_unit.sv
// Program counter and branch sequencer: increment, conditional jump, CALL/RET via a return-address stack.
// Optional macro PC_COND_BRANCH_EN enables cond_sel/flag decoding; when undefined every load/call is taken.
module pc_branch_unit #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             load,
    input  logic                             call,
    input  logic                             ret,
    input  logic [2:0]                       cond_sel,
    input  logic                             flag_zero,
    input  logic                             flag_carry,
    input  logic                             flag_negative,
    input  logic [ADDR_WIDTH-1:0]            jump_addr,
    output logic [ADDR_WIDTH-1:0]            counter_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             branch_taken,
    output logic                             stack_overflow,
    output logic                             stack_underflow
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PW-1:0]         push_idx;
    logic [PW-1:0]         pop_idx;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  cond_true;

    logic [ADDR_WIDTH-1:0] pc_next;
    logic [CW-1:0]         count_next;
    logic                  taken_next;
    logic                  overflow_next;
    logic                  underflow_next;
    logic                  push;

    // The occupancy count doubles as the write pointer; the top entry sits one below it.
    assign push_idx    = stack_count[PW-1:0];
    assign pop_idx     = push_idx - PW'(1);
    assign stack_full  = (stack_count == CW'(STACK_DEPTH));
    assign stack_empty = (stack_count == '0);

`ifdef PC_COND_BRANCH_EN
    always_comb begin
        case (cond_sel)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = flag_zero;
            3'd2:    cond_true = !flag_zero;
            3'd3:    cond_true = flag_carry;
            3'd4:    cond_true = !flag_carry;
            3'd5:    cond_true = flag_negative;
            3'd6:    cond_true = !flag_negative;
            default: cond_true = 1'b0;
        endcase
    end
`else
    logic unused_cond_inputs;
    assign unused_cond_inputs = ^{cond_sel, flag_zero, flag_carry, flag_negative};
    assign cond_true = 1'b1;
`endif

    // Only the highest-priority request acts; a blocked request still consumes the cycle.
    always_comb begin
        pc_next        = counter_out;
        count_next     = stack_count;
        taken_next     = 1'b0;
        overflow_next  = stack_overflow;
        underflow_next = stack_underflow;
        push           = 1'b0;
        if (ret) begin
            if (!stack_empty) begin
                pc_next    = stack_mem[pop_idx];
                count_next = stack_count - CW'(1);
                taken_next = 1'b1;
            end else begin
                underflow_next = 1'b1;
            end
        end else if (call) begin
            if (cond_true) begin
                if (stack_full) begin
                    overflow_next = 1'b1;
                end else begin
                    push       = 1'b1;
                    pc_next    = jump_addr;
                    count_next = stack_count + CW'(1);
                    taken_next = 1'b1;
                end
            end
        end else if (load) begin
            if (cond_true) begin
                pc_next    = jump_addr;
                taken_next = 1'b1;
            end
        end else if (enable) begin
            pc_next = counter_out + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_out     <= RESET_VECTOR;
            stack_count     <= '0;
            branch_taken    <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            counter_out     <= pc_next;
            stack_count     <= count_next;
            branch_taken    <= taken_next;
            stack_overflow  <= overflow_next;
            stack_underflow <= underflow_next;
        end
    end

    // Stack storage needs no reset; the reset gate keeps a CALL during reset from writing.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            stack_mem[push_idx] <= counter_out;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Testbench for pc_branch_unit: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based reference model. Honours PC_COND_BRANCH_EN like the design.
module tb_pc_branch_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [2:0] cond_sel = 3'd0;
    logic       flag_zero = 1'b0;
    logic       flag_carry = 1'b0;
    logic       flag_negative = 1'b0;
    logic [7:0] jump_addr = 8'd0;
    logic [7:0] counter_out;
    logic [2:0] stack_count;
    logic       branch_taken;
    logic       stack_overflow;
    logic       stack_underflow;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    int m_pc = 0;
    int m_stack[$];
    bit m_taken = 1'b0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    pc_branch_unit #(
        .ADDR_WIDTH  (8),
        .STACK_DEPTH (DEPTH),
        .RESET_VECTOR(8'h00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .load           (load),
        .call           (call),
        .ret            (ret),
        .cond_sel       (cond_sel),
        .flag_zero      (flag_zero),
        .flag_carry     (flag_carry),
        .flag_negative  (flag_negative),
        .jump_addr      (jump_addr),
        .counter_out    (counter_out),
        .stack_count    (stack_count),
        .branch_taken   (branch_taken),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [2:0] cs, input bit z, input bit c, input bit n);
`ifdef PC_COND_BRANCH_EN
        bit table_val [8];
        table_val = '{1'b1, z, !z, c, !c, n, !n, 1'b0};
        return table_val[cs];
`else
        return 1'b1;
`endif
    endfunction

    // Reference behaviour: a queue is the stack, and the request priority is written out directly.
    task automatic model_step();
        bit ok;
        ok = cond_ok(cond_sel, flag_zero, flag_carry, flag_negative);
        if (!reset) begin
            m_pc = 0;
            m_stack.delete();
            m_taken = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_taken = 1'b0;
            if (ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                    m_taken = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end else if (call) begin
                if (ok) begin
                    if (m_stack.size() == DEPTH) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_stack.push_back(m_pc);
                        m_pc = jump_addr;
                        m_taken = 1'b1;
                    end
                end
            end else if (load) begin
                if (ok) begin
                    m_pc = jump_addr;
                    m_taken = 1'b1;
                end
            end else if (enable) begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit en, input bit ld, input bit cl, input bit rt,
                                 input logic [2:0] cs, input bit fz, input bit fc, input bit fn,
                                 input logic [7:0] ja);
        @(negedge clk);
        reset = r;
        enable = en;
        load = ld;
        call = cl;
        ret = rt;
        cond_sel = cs;
        flag_zero = fz;
        flag_carry = fc;
        flag_negative = fn;
        jump_addr = ja;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic checkOutput();
        cmp("counter_out", 32'(counter_out), 32'(m_pc));
        cmp("stack_count", 32'(stack_count), 32'(m_stack.size()));
        cmp("branch_taken", 32'(branch_taken), 32'(m_taken));
        cmp("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
        cmp("stack_underflow", 32'(stack_underflow), 32'(m_unf));
    endtask

    task automatic check_lit(input string name, input logic [31:0] dut_v, input logic [31:0] model_v,
                             input logic [31:0] lit);
        cmp(name, dut_v, lit);
        cmp({name, "_model"}, model_v, lit);
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic do_enable();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic do_load(input logic [7:0] ja);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ja);
    endtask
    task automatic do_call(input logic [7:0] ja);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ja);
    endtask
    task automatic do_ret();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    initial begin
        do_reset();
        check_en = 1'b1;
        do_reset();
        check_lit("rst_pc", 32'(counter_out), 32'(m_pc), 32'h00);
        check_lit("rst_count", 32'(stack_count), 32'(m_stack.size()), 32'd0);
        check_lit("rst_taken", 32'(branch_taken), 32'(m_taken), 32'd0);
        check_lit("rst_ovf", 32'(stack_overflow), 32'(m_ovf), 32'd0);
        check_lit("rst_unf", 32'(stack_underflow), 32'(m_unf), 32'd0);

        do_enable();
        check_lit("inc1", 32'(counter_out), 32'(m_pc), 32'h01);
        do_enable();
        do_enable();
        check_lit("inc3", 32'(counter_out), 32'(m_pc), 32'h03);
        do_load(8'hFF);
        check_lit("jmp_ff", 32'(counter_out), 32'(m_pc), 32'hFF);
        do_enable();
        check_lit("wrap", 32'(counter_out), 32'(m_pc), 32'h00);
        check_lit("wrap_taken", 32'(branch_taken), 32'(m_taken), 32'd0);

        do_load(8'h01);
        do_load(8'h0A);
        check_lit("jmp_pc", 32'(counter_out), 32'(m_pc), 32'h0A);
        check_lit("jmp_taken", 32'(branch_taken), 32'(m_taken), 32'd1);
        do_enable();
        check_lit("jmp_inc", 32'(counter_out), 32'(m_pc), 32'h0B);
        check_lit("jmp_pulse_end", 32'(branch_taken), 32'(m_taken), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'h50);
`ifdef PC_COND_BRANCH_EN
        check_lit("jz_fail_pc", 32'(counter_out), 32'(m_pc), 32'h0B);
        check_lit("jz_fail_taken", 32'(branch_taken), 32'(m_taken), 32'd0);
`else
        check_lit("jz_uncond_pc", 32'(counter_out), 32'(m_pc), 32'h50);
        check_lit("jz_uncond_taken", 32'(branch_taken), 32'(m_taken), 32'd1);
`endif
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h60);
        check_lit("jz_pass_pc", 32'(counter_out), 32'(m_pc), 32'h60);

        do_load(8'h05);
        do_call(8'h20);
        check_lit("call1_pc", 32'(counter_out), 32'(m_pc), 32'h20);
        do_load(8'h22);
        do_call(8'h30);
        check_lit("call2_pc", 32'(counter_out), 32'(m_pc), 32'h30);
        check_lit("call2_count", 32'(stack_count), 32'(m_stack.size()), 32'd2);
        do_ret();
        check_lit("ret1_pc", 32'(counter_out), 32'(m_pc), 32'h22);
        check_lit("ret1_taken", 32'(branch_taken), 32'(m_taken), 32'd1);
        do_ret();
        check_lit("ret2_pc", 32'(counter_out), 32'(m_pc), 32'h05);
        check_lit("ret2_count", 32'(stack_count), 32'(m_stack.size()), 32'd0);

        for (int i = 0; i < 4; i++) do_call(8'(8'h10 + i));
        check_lit("full_count", 32'(stack_count), 32'(m_stack.size()), 32'd4);
        do_call(8'h14);
        check_lit("ovf_pc", 32'(counter_out), 32'(m_pc), 32'h13);
        check_lit("ovf_flag", 32'(stack_overflow), 32'(m_ovf), 32'd1);
        check_lit("ovf_count", 32'(stack_count), 32'(m_stack.size()), 32'd4);

        do_reset();
        check_lit("ovf_cleared", 32'(stack_overflow), 32'(m_ovf), 32'd0);
        do_ret();
        check_lit("unf_pc", 32'(counter_out), 32'(m_pc), 32'h00);
        check_lit("unf_flag", 32'(stack_underflow), 32'(m_unf), 32'd1);
        for (int i = 0; i < 5; i++) do_call(8'(8'h10 + i));
        do_enable();
        do_enable();
        check_lit("sticky_pc", 32'(counter_out), 32'(m_pc), 32'h15);
        check_lit("sticky_ovf", 32'(stack_overflow), 32'(m_ovf), 32'd1);
        check_lit("sticky_unf", 32'(stack_underflow), 32'(m_unf), 32'd1);

        do_reset();
        do_load(8'h40);
        do_call(8'h99);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h88);
        check_lit("prio_pc", 32'(counter_out), 32'(m_pc), 32'h40);
        check_lit("prio_count", 32'(stack_count), 32'(m_stack.size()), 32'd0);
        do_load(8'h12);
        do_call(8'h55);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h77);
        check_lit("rst_call_pc", 32'(counter_out), 32'(m_pc), 32'h00);
        check_lit("rst_call_count", 32'(stack_count), 32'(m_stack.size()), 32'd0);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 39) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
